seq_gen: RTL and testbench

- Serial pattern transmitter: the sending end of the single-bit stream that the sequence detector consumes.
- Accepts a WIDTH-bit pattern and a length through a valid/ready load port.
- Shifts the pattern out LSB-first, one bit per clk, with optional continuous looping and abort.
- Its serial output connects directly to the detector's serial input in system-level benches and in the top design.

---
 rtl/seq_gen_if.sv | 29 ++
 rtl/seq_gen.sv | 140 ++++++++++++++
 tb/tb_seq_gen.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_gen_if.sv
// Pattern load port for seq_gen: valid/ready handshake carrying a pattern
// and its length.
//   load_valid : source requests a load
//   load_ready : sink can accept (sink drives)
//   load_data  : pattern, bit 0 transmitted first
//   load_len   : number of bits to send
interface seq_gen_if #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned LEN_W = 4
);
   logic             load_valid;
   logic             load_ready;
   logic [WIDTH-1:0] load_data;
   logic [LEN_W-1:0] load_len;

   modport master (
      output load_valid,
      output load_data,
      output load_len,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  load_len,
      output load_ready
   );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern transmitter. Loads a WIDTH-bit pattern plus length over a
// valid/ready port and shifts it out LSB-first, one bit per clock, with
// optional continuous looping and abort.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld         : pattern load port (slave side)
//   loop       : at end of pattern, high restarts the pattern
//   stop       : abort the current transmission
//   o, o_valid : serial data bit and its qualifier (o is 0 when not valid)
//   busy       : high while shifting (decoded from state)
//   done       : one-cycle pulse on normal completion
//   bit_idx    : index of the bit currently on o
module seq_gen #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   seq_gen_if.slave         ld,
   input  logic             loop,
   input  logic             stop,
   output logic             o,
   output logic             o_valid,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] bit_idx
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic             o_q, o_d;
   logic             ov_q, ov_d;
   logic             done_q, done_d;

   logic [LEN_W-1:0] eff_len_c;
   logic [LEN_W-1:0] nxt_idx_c;
   logic [WIDTH-1:0] pat_sh_c;
   logic             last_c;

   // Requested length clamped to the pattern width
   assign eff_len_c = (ld.load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : ld.load_len;

   // Next bit is selected by shifting the held pattern, so a loop restart
   // only needs the index reset to zero
   assign nxt_idx_c = idx_q + LEN_W'(1);
   assign pat_sh_c  = pat_q >> nxt_idx_c;
   assign last_c    = (idx_q == LEN_W'(len_q - LEN_W'(1)));

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         o_q     <= 1'b0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         o_q     <= o_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      o_d     = o_q;
      ov_d    = ov_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (ld.load_valid) begin
               pat_d = ld.load_data;
               len_d = eff_len_c;
               if (eff_len_c == '0) begin
                  // Empty pattern completes immediately without any output
                  done_d = 1'b1;
               end else begin
                  // First bit goes out at the accept edge itself
                  o_d     = ld.load_data[0];
                  ov_d    = 1'b1;
                  idx_d   = '0;
                  state_d = S_SHIFT;
               end
            end
         end

         S_SHIFT: begin
            if (stop) begin
               o_d     = 1'b0;
               ov_d    = 1'b0;
               idx_d   = '0;
               state_d = S_IDLE;
            end else if (last_c) begin
               if (loop) begin
                  idx_d = '0;
                  o_d   = pat_q[0];
               end else begin
                  o_d     = 1'b0;
                  ov_d    = 1'b0;
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               idx_d = nxt_idx_c;
               o_d   = pat_sh_c[0];
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign ld.load_ready = (state_q == S_IDLE);
   assign busy          = (state_q == S_SHIFT);
   assign o             = o_q;
   assign o_valid       = ov_q;
   assign done          = done_q;
   assign bit_idx       = idx_q;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: per-cycle expected outputs are queued from the pattern
// being sent and popped one per clock after each rising edge.
module tb_seq_gen;

   localparam int unsigned WIDTH = 10;
   localparam int unsigned LEN_W = 4;

   typedef struct packed {
      logic             o;
      logic             ov;
      logic             dn;
      logic             bsy;
      logic             rdy;
      logic [LEN_W-1:0] idx;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             loop;
   logic             stop;
   logic             o;
   logic             o_valid;
   logic             busy;
   logic             done;
   logic [LEN_W-1:0] bit_idx;

   seq_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) ld_if ();

   seq_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld      (ld_if.slave),
      .loop    (loop),
      .stop    (stop),
      .o       (o),
      .o_valid (o_valid),
      .busy    (busy),
      .done    (done),
      .bit_idx (bit_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t sb[$];
   int   total;
   int   bad;

   // Expected observation; in SHIFT o_valid is always high, so busy follows
   // o_valid and load_ready is its complement
   function automatic exp_t mk(input logic o_b, input logic ov_b, input logic dn_b, input int idx);
      exp_t r;
      r.o   = o_b;
      r.ov  = ov_b;
      r.dn  = dn_b;
      r.bsy = ov_b;
      r.rdy = ~ov_b;
      r.idx = LEN_W'(idx);
      return r;
   endfunction

   function automatic exp_t sample();
      exp_t r;
      r.o   = o;
      r.ov  = o_valid;
      r.dn  = done;
      r.bsy = busy;
      r.rdy = ld_if.load_ready;
      r.idx = bit_idx;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l);
      ld_if.load_valid = 1'b1;
      ld_if.load_data  = d;
      ld_if.load_len   = l;
   endtask

   task automatic test_reset();
      exp_t g, e;
      logic [WIDTH-1:0] pat;
      pat = 10'b00_0000_1011;
      g = sample();
      e = mk(1'b0, 1'b0, 1'b0, 0);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL reset_init got{o,v,dn,bsy,rdy,idx}=%b required=%b", g, e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL reset_idle cyc%0d got=%b required=%b", c, g, e);
         end
      end
      // Start a pattern, then reset between edges in the middle of it
      for (int k = 0; k < 3; k++) sb.push_back(mk(pat[k], 1'b1, 1'b0, k));
      load(pat, 4'd4);
      loop = 1'b0;
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL reset_pre cyc%0d got=%b required=%b", c, g, e);
         end
      end
      #3;
      rst_n = 1'b0;
      #1;
      g = sample();
      e = mk(1'b0, 1'b0, 1'b0, 0);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL reset_async got=%b required=%b", g, e);
      end
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL reset_after cyc%0d got=%b required=%b", c, g, e);
         end
      end
   endtask

   task automatic test_basic();
      exp_t g, e;
      logic [WIDTH-1:0] pat;
      pat = 10'b0001101011;
      for (int k = 0; k < 10; k++) sb.push_back(mk(pat[k], 1'b1, 1'b0, k));
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      load(pat, 4'd10);
      loop = 1'b0;
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL basic cyc%0d got=%b required=%b", c, g, e);
         end
      end
   endtask

   task automatic test_loop();
      exp_t g, e;
      logic [WIDTH-1:0] pat;
      pat = 10'b00_0000_1011;
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < 4; k++) sb.push_back(mk(pat[k], 1'b1, 1'b0, k));
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      load(pat, 4'd4);
      loop = 1'b1;
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         // Drop loop during the second pass
         if (c == 4) loop = 1'b0;
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL loop cyc%0d got=%b required=%b", c, g, e);
         end
      end
   endtask

   task automatic test_abort();
      exp_t g, e;
      logic [WIDTH-1:0] pat;
      pat = 10'b1110011101;
      for (int k = 0; k < 4; k++) sb.push_back(mk(pat[k], 1'b1, 1'b0, k));
      for (int k = 0; k < 3; k++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      load(pat, 4'd10);
      loop = 1'b1;
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         stop = (c == 3);
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL abort cyc%0d got=%b required=%b", c, g, e);
         end
      end
      loop = 1'b0;
   endtask

   task automatic test_len_bounds();
      exp_t g, e;
      logic [WIDTH-1:0] pat;
      // Zero length: single done pulse, nothing sent; stop is a no-op in IDLE
      pat = 10'b1111111111;
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      load(pat, 4'd0);
      stop = 1'b1;
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         stop = 1'b0;
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL len0 cyc%0d got=%b required=%b", c, g, e);
         end
      end
      // Oversized length clamps to WIDTH
      pat = 10'b1010011001;
      for (int k = 0; k < 10; k++) sb.push_back(mk(pat[k], 1'b1, 1'b0, k));
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      load(pat, 4'd15);
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL len15 cyc%0d got=%b required=%b", c, g, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t g, e;
      logic [WIDTH-1:0] pa, pb, pc;
      pa = 10'b00000_10110;
      pb = 10'b00000_01101;
      pc = 10'b11111_11111;
      for (int k = 0; k < 5; k++) sb.push_back(mk(pa[k], 1'b1, 1'b0, k));
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      for (int k = 0; k < 5; k++) sb.push_back(mk(pb[k], 1'b1, 1'b0, k));
      sb.push_back(mk(1'b0, 1'b0, 1'b1, 0));
      sb.push_back(mk(1'b0, 1'b0, 1'b0, 0));
      load(pa, 4'd5);
      loop = 1'b0;
      for (int c = 0; sb.size() != 0; c++) begin
         step();
         ld_if.load_valid = 1'b0;
         // Pulse a load while busy, then hold the next load through done
         if (c == 1) load(pc, 4'd3);
         if (c >= 2 && c <= 5) load(pb, 4'd5);
         e = sb.pop_front();
         g = sample();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL b2b cyc%0d got=%b required=%b", c, g, e);
         end
      end
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      rst_n            = 1'b0;
      loop             = 1'b0;
      stop             = 1'b0;
      ld_if.load_valid = 1'b0;
      ld_if.load_data  = '0;
      ld_if.load_len   = '0;
      #3;
      test_reset();
      test_basic();
      test_loop();
      test_abort();
      test_len_bounds();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
